// File: rtl/song_reader_if.sv
// Song reader bus: play/song controls, note_player handshake and song ROM port.
interface song_reader_if #(
  parameter int unsigned NOTE_W    = 6,
  parameter int unsigned DUR_W     = 6,
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned IDX_BITS  = 5
);
  logic                          play;
  logic [SONG_BITS-1:0]          song;
  logic                          note_done;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0]       rom_data;
  logic [NOTE_W-1:0]             note;
  logic [DUR_W-1:0]              duration;
  logic                          new_note;
  logic                          song_done;

  modport master (
    input  play, song, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );

  modport slave (
    output play, song, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Walks a song ROM and hands each {note, duration} to note_player, one note per done_with_note.
module song_reader #(
  parameter int unsigned NOTE_W    = 6,
  parameter int unsigned DUR_W     = 6,
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned IDX_BITS  = 5
) (
  input  logic          clk,
  input  logic          reset,
  song_reader_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] END   = 3'd5;

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

  logic [2:0]           state_q, state_d;
  logic [IDX_BITS-1:0]  index_q, index_d;
  logic [SONG_BITS-1:0] song_q;
  logic [NOTE_W-1:0]    note_q, note_d;
  logic [DUR_W-1:0]     dur_q, dur_d;
  logic                 song_done_q, song_done_d;
  logic                 new_note_c;

  logic [NOTE_W-1:0]    rom_note;
  logic [DUR_W-1:0]     rom_dur;

  assign {rom_note, rom_dur} = bus.rom_data;

  // ROM address follows the live song input so it is valid while reset is held
  assign bus.rom_addr  = {bus.song, index_q};
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.new_note  = new_note_c;
  assign bus.song_done = song_done_q;

  // Next-state and strobe logic
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    note_d      = note_q;
    dur_d       = dur_q;
    song_done_d = 1'b0;
    new_note_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.play) state_d = FETCH;
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        note_d = rom_note;
        dur_d  = rom_dur;
        if (rom_dur == '0) begin
          song_done_d = 1'b1;
          state_d     = END;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.play) begin
          new_note_c = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.note_done) begin
          if (index_q == IDX_LAST) begin
            song_done_d = 1'b1;
            state_d     = END;
          end else begin
            index_d = index_q + IDX_BITS'(1);
            state_d = bus.play ? FETCH : IDLE;
          end
        end
      end
      END: begin
        if (!bus.play) begin
          index_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new song selection restarts from the top and suppresses any strobe or end pulse
    if (bus.song != song_q) begin
      state_d     = IDLE;
      index_d     = '0;
      song_done_d = 1'b0;
      new_note_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      song_q      <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      song_q      <= bus.song;
      note_q      <= note_d;
      dur_q       <= dur_d;
      song_done_q <= song_done_d;
    end
  end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Initiator that feeds the note_player. Walks a song ROM entry by entry.
- Presents each note/duration pair with a one-cycle new_note strobe, then waits for the player's done_with_note before fetching the next entry.
- Sits between the top-level song select/play controls and note_player's note_to_load/duration_to_load/load_new_note/done_with_note interface.

Parameters:
- NOTE_W, 6, note code width (matches note_player note_to_load)
- DUR_W, 6, duration width in 1/48ths of a beat (matches duration_to_load)
- SONG_BITS, 2, song select width
- IDX_BITS, 5, note index width; songs hold 2^IDX_BITS entries

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- play  in  1  high = advance through song; low = hold position
- song  in  SONG_BITS  selected song
- note_done  in  1  one-cycle pulse from note_player done_with_note
- rom_addr  out  SONG_BITS+IDX_BITS  song ROM address = {song, index}
- rom_data  in  NOTE_W+DUR_W  ROM word {note, duration}; valid exactly one cycle after rom_addr changes
- note  out  NOTE_W  note to load, held stable from ISSUE until next ISSUE
- duration  out  DUR_W  duration to load, held stable likewise
- new_note  out  1  one-cycle load strobe to note_player
- song_done  out  1  one-cycle pulse when the song ends

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, index=0, song_q=0
  - note=0, duration=0, new_note=0, song_done=0
  - rom_addr={song,0} (combinational from song and index)
- States: IDLE, FETCH, LATCH, ISSUE, WAIT, END.
- IDLE: if play=1 -> FETCH, else stay.
- FETCH: rom_addr already presents {song_q,index}; unconditionally -> LATCH (ROM read latency 1).
- LATCH: capture rom_data into note/duration registers.
  - If captured duration==0 (end marker): pulse song_done next cycle, go END; new_note is not asserted.
  - Otherwise -> ISSUE.
- ISSUE: new_note=1 for exactly this cycle, gated by play.
  - If play=0, new_note=0; stay in ISSUE until play=1.
  - Then -> WAIT.
- WAIT: note_done=1 -> advance.
  - If index==2^IDX_BITS-1: pulse song_done, go END, index stays.
  - Else index<=index+1; go FETCH if play=1, otherwise IDLE.
  - note_done is ignored in every state other than WAIT.
- END: hold outputs; new_note=0.
  - play=0 -> IDLE with index=0 (replay from start on next play).
- Latency: play rising in IDLE -> new_note high on the 3rd rising edge (IDLE->FETCH->LATCH->ISSUE). Consecutive notes: note_done in WAIT -> next new_note 3 cycles later.
- Song change:
  - song_q registers song every cycle.
  - song != song_q in any state -> state=IDLE, index=0 next cycle. This overrides all other transitions, including a simultaneous note_done or end condition.
  - song_done is not pulsed on a song change.
- Simultaneous events:
  - note_done and play falling in the same WAIT cycle: the advance still occurs; the next state is IDLE.
  - song_done and new_note are never high together.
- Widths: index wraps only by entering END, never by arithmetic overflow.
- note and duration outputs keep their last value while in IDLE, WAIT and END.

Test Plan:
- Reset low mid-WAIT with note=44 loaded -> all outputs 0 immediately (asynchronous), index=0; after release, play=1 -> rom_addr={song,5'd0}, new_note at 3rd edge.
- ROM song0 = {44,6},{45,4},{2,4},{x,0}; play=1, note_done pulsed 20 cycles after each new_note -> new_note pulses carry (44,6),(45,4),(2,4); song_done pulses once 2 cycles after the third note_done; no 4th new_note.
- Full 32-entry song with no end marker -> 32 new_note pulses, song_done after the 32nd note_done, rom_addr never exceeds {song,5'd31}.
- play=0 during ISSUE of note 45 -> new_note stays 0; play=1 after 50 cycles -> single new_note with (45,4).
- song changed from 0 to 1 during WAIT at index 2 -> IDLE, index=0; next play gives rom_addr={2'd1,5'd0}; no song_done.
- note_done pulsed in IDLE, FETCH and ISSUE -> no index change, no extra new_note.
